// File: rtl/dt_pkg.sv
// Shared constants, FIFO entry layout and readout state enum for the
// distance-transform result readout path.
`timescale 1ns/1ps
package dt_pkg;

  localparam int IMG_W      = 128;
  localparam int IMG_H      = 128;
  localparam int ADDR_W     = 14;
  localparam int DW         = 8;
  localparam int IMG_PIX    = IMG_W * IMG_H;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  typedef struct packed {
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [DW-1:0]     data;
  } rd_entry_t;

  // True for the final raster address of the image.
  function automatic logic is_last_pix(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(IMG_PIX - 1));
  endfunction

endpackage

// File: rtl/res_readout_if.sv
// Result-RAM read port plus the valid/ready pixel stream of the readout.
// master = the readout engine, slave = RAM and pixel sink.
`timescale 1ns/1ps
interface res_readout_if;
  import dt_pkg::*;

  logic              res_rd;
  logic [ADDR_W-1:0] res_addr;
  logic [DW-1:0]     res_di;

  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_last;

  modport master (
    output res_rd, res_addr,
    input  res_di,
    output out_valid, out_data, out_addr, out_last,
    input  out_ready
  );

  modport slave (
    input  res_rd, res_addr,
    output res_di,
    input  out_valid, out_data, out_addr, out_last,
    output out_ready
  );

endinterface

// File: rtl/res_readout_rd_fifo.sv
// Small synchronous prefetch FIFO (module rd_fifo) with occupancy count;
// push and pop in the same cycle leave the count unchanged. DEPTH must be a power of two.
`timescale 1ns/1ps
module rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_s;
  logic             pop_s;

  // Guard against pop-when-empty and push-when-full regardless of the caller.
  always_comb begin
    pop_s  = pop && (count_r != CW'(0));
    push_s = push && ((count_r != FULL_C) || pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign empty = (count_r == CW'(0));

endmodule

// File: rtl/res_readout.sv
// Streams the distance-transform result RAM out in raster order after start.
// Optional statistics outputs (stat_max, stat_nz) with RES_READOUT_STAT_EN defined.
`timescale 1ns/1ps
module res_readout
  import dt_pkg::*;
#(
  parameter int FIFO_DEPTH = dt_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  res_readout_if.master     bus,
  output logic              busy,
  output logic              done
`ifdef RES_READOUT_STAT_EN
  ,
  output logic [DW-1:0]     stat_max,
  output logic [ADDR_W:0]   stat_nz
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = $bits(rd_entry_t);
  localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0] PIX_C   = (ADDR_W + 1)'(IMG_PIX);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W + 1)'(IMG_PIX - 1);

  rd_state_e         state_r;
  logic [ADDR_W:0]   issue_cnt_r;
  logic              inflight_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              busy_r;
  logic              done_r;

  logic              issue_s;
  logic              start_acc_s;
  logic              transfer_s;
  logic [CW:0]       occ_s;
  logic [CW-1:0]     fifo_count_s;
  logic              fifo_empty_s;
  rd_entry_t         push_entry_s;
  rd_entry_t         head_s;
  logic [EW-1:0]     fifo_dout_s;

  // Credit check: FIFO entries plus the read still in flight must leave room.
  always_comb begin
    occ_s       = {1'b0, fifo_count_s} + {{CW{1'b0}}, inflight_r};
    issue_s     = (state_r == RUN) && (occ_s < DEPTH_C) && (issue_cnt_r < PIX_C);
    start_acc_s = start && ((state_r == IDLE) || (state_r == DONE));
    transfer_s  = !fifo_empty_s && bus.out_ready;
    head_s      = rd_entry_t'(fifo_dout_s);
  end

  // Capture entry for the data returning from last cycle's read.
  always_comb begin
    push_entry_s.last = is_last_pix(rd_addr_r);
    push_entry_s.addr = rd_addr_r;
    push_entry_s.data = bus.res_di;
  end

  // Readout sequencer with registered busy/done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      issue_cnt_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            state_r     <= RUN;
            issue_cnt_r <= '0;
            busy_r      <= 1'b1;
            done_r      <= 1'b0;
          end
        end
        RUN: begin
          if (issue_s) begin
            issue_cnt_r <= issue_cnt_r + (ADDR_W + 1)'(1);
            if (issue_cnt_r == LAST_C) begin
              state_r <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (transfer_s && head_s.last) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Remember whether a read is outstanding and which address it targets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_r <= 1'b0;
      rd_addr_r  <= '0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        rd_addr_r <= issue_cnt_r[ADDR_W-1:0];
      end
    end
  end

  rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_r),
    .din   (push_entry_s),
    .pop   (transfer_s),
    .dout  (fifo_dout_s),
    .count (fifo_count_s),
    .empty (fifo_empty_s)
  );

  // RAM strobe and FIFO-head stream outputs; fields read zero when nothing is valid.
  always_comb begin
    bus.res_rd    = issue_s;
    bus.res_addr  = issue_cnt_r[ADDR_W-1:0];
    bus.out_valid = !fifo_empty_s;
    if (!fifo_empty_s) begin
      bus.out_data = head_s.data;
      bus.out_addr = head_s.addr;
      bus.out_last = head_s.last;
    end else begin
      bus.out_data = '0;
      bus.out_addr = '0;
      bus.out_last = 1'b0;
    end
  end

  assign busy = busy_r;
  assign done = done_r;

`ifdef RES_READOUT_STAT_EN
  logic [DW-1:0]   stat_max_r;
  logic [ADDR_W:0] stat_nz_r;

  // Running maximum and nonzero count over handed-off pixels.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_max_r <= '0;
      stat_nz_r  <= '0;
    end else if (start_acc_s) begin
      stat_max_r <= '0;
      stat_nz_r  <= '0;
    end else if (transfer_s) begin
      if (head_s.data > stat_max_r) begin
        stat_max_r <= head_s.data;
      end
      if (head_s.data != DW'(0)) begin
        stat_nz_r <= stat_nz_r + (ADDR_W + 1)'(1);
      end
    end
  end

  assign stat_max = stat_max_r;
  assign stat_nz  = stat_nz_r;
`else
  logic unused_s;
  assign unused_s = start_acc_s;
`endif

endmodule
